// File: rtl/dwc_mobile_storage_clk_switch_seq_if.sv
// rtl/dwc_mobile_storage_clk_switch_seq_if.sv - request and clock-generator signals of the clock-switch sequencer
interface dwc_mobile_storage_clk_switch_seq_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_enable;
  logic [1:0] req_mux;
  logic [6:0] req_drv_phase;
  logic [6:0] req_smpl_phase;
  logic       clk_ready;
  logic       clk_enable;
  logic [1:0] ext_clk_mux_ctrl;
  logic [6:0] clk_drv_phase_ctrl;
  logic [6:0] clk_smpl_phase_ctrl;
  logic       busy;
  logic       done;
  logic       done_err;

  modport slave (
    input  req_valid, req_enable, req_mux, req_drv_phase, req_smpl_phase, clk_ready,
    output req_ready, clk_enable, ext_clk_mux_ctrl, clk_drv_phase_ctrl,
           clk_smpl_phase_ctrl, busy, done, done_err
  );

  modport master (
    output req_valid, req_enable, req_mux, req_drv_phase, req_smpl_phase, clk_ready,
    input  req_ready, clk_enable, ext_clk_mux_ctrl, clk_drv_phase_ctrl,
           clk_smpl_phase_ctrl, busy, done, done_err
  );
endinterface

// File: rtl/dwc_mobile_storage_clk_switch_seq.sv
// rtl/dwc_mobile_storage_clk_switch_seq.sv - stops the card-clock generator, applies new divider/phase config, restarts it
module dwc_mobile_storage_clk_switch_seq #(
  parameter int SETTLE_CYC = 4,
  parameter int TO_CYC     = 512,
  parameter int TO_W       = 10
) (
  input  logic                               ext_clk,
  input  logic                               rst,
  dwc_mobile_storage_clk_switch_seq_if.slave bus
);
  localparam int ST_W = $clog2(SETTLE_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_STOP, S_SETTLE, S_START, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_cap_enable;
  logic [1:0]      r_cap_mux;
  logic [6:0]      r_cap_drv, r_cap_smpl;
  logic            r_clk_enable;
  logic [1:0]      r_mux;
  logic [6:0]      r_drv, r_smpl;
  logic            r_err;
  logic [TO_W-1:0] r_to_cnt;
  logic [ST_W-1:0] r_settle_cnt;

  logic w_accept, w_load, w_en_set, w_en_clr, w_err_nxt, w_to_max, w_settle_end, w_entry;

  assign w_accept     = bus.req_valid && (r_state == S_IDLE);
  assign w_to_max     = (r_to_cnt == TO_W'(TO_CYC - 1));
  assign w_settle_end = (r_settle_cnt == ST_W'(SETTLE_CYC - 1));
  assign w_entry      = (w_state_nxt != r_state);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_en_set    = 1'b0;
    w_en_clr    = 1'b0;
    w_err_nxt   = r_err;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_STOP;
          w_en_clr    = 1'b1;
        end
      end
      S_STOP: begin
        if (!bus.clk_ready) begin
          w_state_nxt = S_SETTLE;
          w_load      = 1'b1;
        end else if (w_to_max) begin
          w_state_nxt = S_DONE;
          w_err_nxt   = 1'b1;
        end
      end
      S_SETTLE: begin
        if (w_settle_end) begin
          if (r_cap_enable) begin
            w_state_nxt = S_START;
            w_en_set    = 1'b1;
          end else begin
            w_state_nxt = S_DONE;
            w_err_nxt   = 1'b0;
          end
        end
      end
      S_START: begin
        if (bus.clk_ready) begin
          w_state_nxt = S_DONE;
          w_err_nxt   = 1'b0;
        end else if (w_to_max) begin
          w_state_nxt = S_DONE;
          w_en_clr    = 1'b1;
          w_err_nxt   = 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ext_clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cap_enable <= 1'b0;
      r_cap_mux    <= '0;
      r_cap_drv    <= '0;
      r_cap_smpl   <= '0;
      r_clk_enable <= 1'b0;
      r_mux        <= '0;
      r_drv        <= '0;
      r_smpl       <= '0;
      r_err        <= 1'b0;
      r_to_cnt     <= '0;
      r_settle_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err_nxt;
      if (w_accept) begin
        r_cap_enable <= bus.req_enable;
        r_cap_mux    <= bus.req_mux;
        r_cap_drv    <= bus.req_drv_phase;
        r_cap_smpl   <= bus.req_smpl_phase;
      end
      // Config reaches the generator only while its clocks are gated off
      if (w_load) begin
        r_mux  <= r_cap_mux;
        r_drv  <= r_cap_drv;
        r_smpl <= r_cap_smpl;
      end
      if (w_en_set) begin
        r_clk_enable <= 1'b1;
      end else if (w_en_clr) begin
        r_clk_enable <= 1'b0;
      end
      if (w_entry) begin
        r_to_cnt <= '0;
      end else if (((r_state == S_STOP) || (r_state == S_START)) && (r_to_cnt != '1)) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      if (w_entry) begin
        r_settle_cnt <= '0;
      end else if (r_state == S_SETTLE) begin
        r_settle_cnt <= r_settle_cnt + 1'b1;
      end
    end
  end

  assign bus.req_ready           = (r_state == S_IDLE);
  assign bus.busy                = (r_state != S_IDLE);
  assign bus.done                = (r_state == S_DONE);
  assign bus.done_err            = (r_state == S_DONE) && r_err;
  assign bus.clk_enable          = r_clk_enable;
  assign bus.ext_clk_mux_ctrl    = r_mux;
  assign bus.clk_drv_phase_ctrl  = r_drv;
  assign bus.clk_smpl_phase_ctrl = r_smpl;
endmodule

// File: tb/tb_dwc_mobile_storage_clk_switch_seq.sv
// tb/tb_dwc_mobile_storage_clk_switch_seq.sv - directed bench for the clock-switch sequencer with a generator model
module tb_dwc_mobile_storage_clk_switch_seq;
  logic ext_clk = 1'b0;
  logic rst     = 1'b1;
  int   n_chk   = 0;
  int   n_pass  = 0;

  // 0: generator model, 1: clk_ready stuck high, 2: clk_ready stuck low
  int         ready_mode = 0;
  logic [5:0] en_hist    = '0;
  logic       m_ready    = 1'b0;

  dwc_mobile_storage_clk_switch_seq_if u_if ();

  dwc_mobile_storage_clk_switch_seq #(
    .SETTLE_CYC(4),
    .TO_CYC    (512),
    .TO_W      (10)
  ) u_dut (
    .ext_clk(ext_clk),
    .rst    (rst),
    .bus    (u_if.slave)
  );

  always #5 ext_clk = ~ext_clk;

  // Ready rises after six enabled cycles, drops two cycles after enable falls
  always @(posedge ext_clk) begin
    en_hist <= {en_hist[4:0], u_if.clk_enable};
    if ({en_hist[4:0], u_if.clk_enable} == 6'h3f) m_ready <= 1'b1;
    else if ({en_hist[0], u_if.clk_enable} == 2'b00) m_ready <= 1'b0;
  end

  assign u_if.clk_ready = (ready_mode == 0) ? m_ready : (ready_mode == 1);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic issue(input logic en, input logic [1:0] mux, input logic [6:0] drv,
                       input logic [6:0] smpl);
    @(negedge ext_clk);
    chk("req_ready_before_issue", u_if.req_ready, 1'b1);
    u_if.req_valid      = 1'b1;
    u_if.req_enable     = en;
    u_if.req_mux        = mux;
    u_if.req_drv_phase  = drv;
    u_if.req_smpl_phase = smpl;
    @(posedge ext_clk);
    #1 u_if.req_valid = 1'b0;
  endtask

  task automatic wait_done(output int cycles, output int en_first, output int en_hi,
                           output int en_lo);
    cycles   = 0;
    en_first = -1;
    en_hi    = 0;
    en_lo    = 0;
    while (1) begin
      @(negedge ext_clk);
      if (u_if.done) break;
      if (u_if.clk_enable) begin
        if (en_first < 0) en_first = cycles;
        en_hi++;
      end else begin
        en_lo++;
      end
      cycles++;
      if (cycles > 2000) begin
        chk("done_within_budget", 1'b0, 1'b1);
        break;
      end
    end
  endtask

  task automatic chk_ctrl(input string tag, input logic [1:0] mux, input logic [6:0] drv,
                          input logic [6:0] smpl);
    chk({tag, "_mux"}, u_if.ext_clk_mux_ctrl, mux);
    chk({tag, "_drv"}, u_if.clk_drv_phase_ctrl, drv);
    chk({tag, "_smpl"}, u_if.clk_smpl_phase_ctrl, smpl);
  endtask

  initial begin
    int cyc, en_first, en_hi, en_lo, n_done, guard;
    u_if.req_valid      = 1'b0;
    u_if.req_enable     = 1'b0;
    u_if.req_mux        = '0;
    u_if.req_drv_phase  = '0;
    u_if.req_smpl_phase = '0;
    repeat (3) @(negedge ext_clk);
    chk("rst_clk_enable", u_if.clk_enable, 1'b0);
    chk_ctrl("rst", 2'd0, 7'h00, 7'h00);
    chk("rst_busy", u_if.busy, 1'b0);
    chk("rst_done", {u_if.done, u_if.done_err}, 2'b00);
    chk("rst_req_ready", u_if.req_ready, 1'b1);
    rst = 1'b0;

    // First start from a stopped generator
    issue(1'b1, 2'd1, 7'h03, 7'h05);
    wait_done(cyc, en_first, en_hi, en_lo);
    chk("t1_en_rise_cycle", en_first, 5);
    chk("t1_done_cycle", cyc, 12);
    chk("t1_done_err", u_if.done_err, 1'b0);
    chk("t1_clk_enable", u_if.clk_enable, 1'b1);
    chk_ctrl("t1", 2'd1, 7'h03, 7'h05);
    @(negedge ext_clk);
    chk("t1_done_one_cycle", u_if.done, 1'b0);
    chk("t1_idle", {u_if.busy, u_if.req_ready}, 2'b01);

    // Reconfigure a running clock: config must wait for clk_ready to fall
    issue(1'b1, 2'd3, 7'h00, 7'h0A);
    @(negedge ext_clk);
    chk("t2_en_fall", u_if.clk_enable, 1'b0);
    chk("t2_busy", {u_if.busy, u_if.req_ready}, 2'b10);
    guard = 0;
    while (u_if.clk_ready && guard < 20) begin
      @(negedge ext_clk);
      guard++;
    end
    chk("t2_ready_fell", u_if.clk_ready, 1'b0);
    chk_ctrl("t2_old", 2'd1, 7'h03, 7'h05);
    @(negedge ext_clk);
    chk_ctrl("t2_new", 2'd3, 7'h00, 7'h0A);
    wait_done(cyc, en_first, en_hi, en_lo);
    chk("t2_done_err", u_if.done_err, 1'b0);
    chk("t2_clk_enable", u_if.clk_enable, 1'b1);

    // Stop request: no START phase
    issue(1'b0, 2'd0, 7'h7F, 7'h40);
    wait_done(cyc, en_first, en_hi, en_lo);
    chk("t3_done_err", u_if.done_err, 1'b0);
    chk("t3_never_enabled", en_hi, 0);
    chk("t3_clk_enable", u_if.clk_enable, 1'b0);
    chk_ctrl("t3", 2'd0, 7'h7F, 7'h40);
    repeat (3) @(negedge ext_clk);
    chk("t3_enable_stays_low", u_if.clk_enable, 1'b0);

    // STOP timeout: generator never drops clk_ready
    ready_mode = 1;
    issue(1'b1, 2'd2, 7'h11, 7'h22);
    wait_done(cyc, en_first, en_hi, en_lo);
    chk("t4_stop_cycles", cyc, 512);
    chk("t4_done_err", u_if.done_err, 1'b1);
    chk("t4_clk_enable", u_if.clk_enable, 1'b0);
    chk_ctrl("t4_unchanged", 2'd0, 7'h7F, 7'h40);

    // START timeout: generator never reports ready
    ready_mode = 2;
    issue(1'b1, 2'd2, 7'h11, 7'h22);
    wait_done(cyc, en_first, en_hi, en_lo);
    chk("t5_en_rise_cycle", en_first, 5);
    chk("t5_en_high_cycles", en_hi, 512);
    chk("t5_done_err", u_if.done_err, 1'b1);
    chk("t5_clk_enable", u_if.clk_enable, 1'b0);
    chk_ctrl("t5", 2'd2, 7'h11, 7'h22);

    // Request while busy is dropped, not queued
    ready_mode = 0;
    repeat (5) @(negedge ext_clk);
    issue(1'b1, 2'd1, 7'h33, 7'h44);
    repeat (2) @(negedge ext_clk);
    chk("t6_ready_while_busy", u_if.req_ready, 1'b0);
    u_if.req_valid = 1'b1;
    u_if.req_enable = 1'b0;
    u_if.req_mux = 2'd3;
    u_if.req_drv_phase = 7'h00;
    u_if.req_smpl_phase = 7'h00;
    @(negedge ext_clk);
    u_if.req_valid = 1'b0;
    wait_done(cyc, en_first, en_hi, en_lo);
    chk("t6_done_err", u_if.done_err, 1'b0);
    chk_ctrl("t6", 2'd1, 7'h33, 7'h44);
    n_done = 0;
    repeat (20) begin
      @(negedge ext_clk);
      if (u_if.done) n_done++;
    end
    chk("t6_no_second_done", n_done, 0);
    chk("t6_clk_enable", u_if.clk_enable, 1'b1);

    // Same config again still cycles the clock off and on
    issue(1'b1, 2'd1, 7'h33, 7'h44);
    wait_done(cyc, en_first, en_hi, en_lo);
    chk("t7_enable_dropped", en_lo > 0, 1'b1);
    chk("t7_done_err", u_if.done_err, 1'b0);
    chk("t7_clk_enable", u_if.clk_enable, 1'b1);

    // Reset in START with a stray request pending
    issue(1'b1, 2'd2, 7'h05, 7'h06);
    @(negedge ext_clk);
    guard = 0;
    while (!u_if.clk_enable && guard < 30) begin
      @(negedge ext_clk);
      guard++;
    end
    chk("t8_reached_start", u_if.clk_enable, 1'b1);
    u_if.req_valid = 1'b1;
    @(posedge ext_clk);
    #1 u_if.req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t8_rst_clk_enable", u_if.clk_enable, 1'b0);
    chk_ctrl("t8_rst", 2'd0, 7'h00, 7'h00);
    chk("t8_rst_busy_done", {u_if.busy, u_if.done, u_if.done_err}, 3'b000);
    chk("t8_rst_req_ready", u_if.req_ready, 1'b1);
    @(negedge ext_clk);
    rst = 1'b0;
    n_done = 0;
    repeat (30) begin
      @(negedge ext_clk);
      if (u_if.done) n_done++;
    end
    chk("t8_no_done_after_rst", n_done, 0);
    chk("t8_idle", u_if.busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
